// File: rtl/seq_muldiv_unit_if.sv
// Handshake and data bundle between the execute-stage control (master) and the
// multi-cycle multiply/divide unit (slave).
interface seq_muldiv_unit_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned FLAG_W = 16
);
    logic              start;
    logic              op_div;
    logic [WIDTH-1:0]  operand_1;
    logic [WIDTH-1:0]  operand_2;
    logic              flush;
    logic [FLAG_W-1:0] current_flags;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result_0;
    logic [WIDTH-1:0]  result_1;
    logic [FLAG_W-1:0] next_flags;

    modport master (
        output start, op_div, operand_1, operand_2, flush, current_flags,
        input  busy, done, result_0, result_1, next_flags
    );

    modport slave (
        input  start, op_div, operand_1, operand_2, flush, current_flags,
        output busy, done, result_0, result_1, next_flags
    );
endinterface

// File: rtl/seq_muldiv_unit.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring), one iteration per clock,
// with start/busy/done handshake, flush abort and registered flag update.
module seq_muldiv_unit #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned FLAG_W = 16
) (
    input logic              clk,
    input logic              reset,
    seq_muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               op_div_q, op_div_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;
    logic [WIDTH-1:0]   res0_q, res0_d, res1_q, res1_d;
    logic [FLAG_W-1:0]  nflags_q, nflags_d;

    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    logic               fin, fin_div, fin_dz;
    logic [WIDTH-1:0]   fin_r0, fin_r1;
    logic [FLAG_W-1:0]  fin_base;

    // One iteration of each algorithm on the current accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (div_diff[WIDTH+1]) begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        flags_d  = flags_q;
        fin      = 1'b0;
        fin_div  = op_div_q;
        fin_dz   = 1'b0;
        fin_r0   = acc_q[WIDTH-1:0];
        fin_r1   = acc_q[2*WIDTH-1:WIDTH];
        fin_base = flags_q;
        accept   = bus.start && !bus.flush && (state_q != StRun);

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    op_div_d = bus.op_div;
                    flags_d  = bus.current_flags;
                    cnt_d    = CntW'(WIDTH);
                    if (bus.op_div) begin
                        opnd_d = bus.operand_2;
                        acc_d  = {{WIDTH{1'b0}}, bus.operand_1};
                    end else begin
                        opnd_d = bus.operand_1;
                        acc_d  = {{WIDTH{1'b0}}, bus.operand_2};
                    end
                    if (bus.op_div && (bus.operand_2 == '0)) begin
                        state_d  = StDone;
                        cnt_d    = '0;
                        fin      = 1'b1;
                        fin_div  = 1'b1;
                        fin_dz   = 1'b1;
                        fin_r0   = '1;
                        fin_r1   = bus.operand_1;
                        fin_base = bus.current_flags;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (bus.flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    acc_d = op_div_q ? div_next : mul_next;
                    if (cnt_q == CntW'(1)) begin
                        state_d = StDone;
                        fin     = 1'b1;
                        fin_r0  = acc_d[WIDTH-1:0];
                        fin_r1  = acc_d[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        res0_d   = res0_q;
        res1_d   = res1_q;
        nflags_d = nflags_q;
        if (fin) begin
            res0_d      = fin_r0;
            res1_d      = fin_r1;
            nflags_d    = fin_base;
            nflags_d[0] = !fin_div && (fin_r1 != '0);
            nflags_d[1] = fin_dz;
            nflags_d[6] = fin_r0[WIDTH-1];
            nflags_d[7] = fin_div ? (fin_r0 == '0) : ({fin_r1, fin_r0} == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            flags_q  <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            nflags_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            flags_q  <= flags_d;
            res0_q   <= res0_d;
            res1_q   <= res1_d;
            nflags_q <= nflags_d;
        end
    end

    assign bus.busy       = (state_q == StRun);
    assign bus.done       = (state_q == StDone);
    assign bus.result_0   = res0_q;
    assign bus.result_1   = res1_q;
    assign bus.next_flags = nflags_q;
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed bench for seq_muldiv_unit: a WIDTH=16 instance for the main scenarios and a
// WIDTH=32 instance for the wide multiply.
module tb_seq_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    seq_muldiv_unit_if #(.WIDTH(16), .FLAG_W(16)) bus16 ();
    seq_muldiv_unit_if #(.WIDTH(32), .FLAG_W(16)) bus32 ();

    seq_muldiv_unit #(.WIDTH(16), .FLAG_W(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    seq_muldiv_unit #(.WIDTH(32), .FLAG_W(16)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Issue one op on the 16-bit unit; returns edges from the accepting edge (counted as 1)
    // until done is seen, and the number of sampled busy cycles.
    task automatic run16(input logic div, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] fl, output int edges, output int busy_n);
        @(negedge clk);
        bus16.start         = 1'b1;
        bus16.op_div        = div;
        bus16.operand_1     = a;
        bus16.operand_2     = b;
        bus16.current_flags = fl;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        edges  = 1;
        busy_n = 0;
        while (!bus16.done && edges < 60) begin
            if (bus16.busy) busy_n++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int lat;
        int bsy;
        int n;
        logic seen;

        bus16.start = 0; bus16.op_div = 0; bus16.operand_1 = 0; bus16.operand_2 = 0;
        bus16.flush = 0; bus16.current_flags = 0;
        bus32.start = 0; bus32.op_div = 0; bus32.operand_1 = 0; bus32.operand_2 = 0;
        bus32.flush = 0; bus32.current_flags = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus16.busy), 64'd0);
        check("rst_done", 64'(bus16.done), 64'd0);
        check("rst_r0", 64'(bus16.result_0), 64'd0);
        check("rst_r1", 64'(bus16.result_1), 64'd0);
        check("rst_flags", 64'(bus16.next_flags), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: 0xFFFF x 2
        run16(1'b0, 16'hFFFF, 16'h0002, 16'h0000, lat, bsy);
        check("mul1_latency", 64'(lat), 64'd17);
        check("mul1_busy_cycles", 64'(bsy), 64'd16);
        check("mul1_r1", 64'(bus16.result_1), 64'h0001);
        check("mul1_r0", 64'(bus16.result_0), 64'hFFFE);
        check("mul1_flags", 64'(bus16.next_flags), 64'h0041);
        @(posedge clk);
        #1;
        check("mul1_done_pulse", 64'(bus16.done), 64'd0);

        // 2: divides
        run16(1'b1, 16'd20, 16'd5, 16'h0010, lat, bsy);
        check("div1_latency", 64'(lat), 64'd17);
        check("div1_r0", 64'(bus16.result_0), 64'h0004);
        check("div1_r1", 64'(bus16.result_1), 64'h0000);
        check("div1_flags", 64'(bus16.next_flags), 64'h0010);
        run16(1'b1, 16'd7, 16'd9, 16'h0000, lat, bsy);
        check("div2_r0", 64'(bus16.result_0), 64'h0000);
        check("div2_r1", 64'(bus16.result_1), 64'h0007);
        check("div2_flags", 64'(bus16.next_flags), 64'h0080);

        // 3: divide by zero
        run16(1'b1, 16'd20, 16'd0, 16'h0000, lat, bsy);
        check("dz_latency", 64'(lat), 64'd1);
        check("dz_r0", 64'(bus16.result_0), 64'hFFFF);
        check("dz_r1", 64'(bus16.result_1), 64'h0014);
        check("dz_flags", 64'(bus16.next_flags), 64'h0042);

        // 4: flush mid-run, then flush blocking a start in IDLE, then a clean MUL
        @(negedge clk);
        bus16.start = 1'b1; bus16.op_div = 1'b0;
        bus16.operand_1 = 16'd10; bus16.operand_2 = 16'd20; bus16.current_flags = 16'h0000;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus16.flush = 1'b1;
        @(posedge clk);
        #1;
        bus16.flush = 1'b0;
        check("flush_busy", 64'(bus16.busy), 64'd0);
        check("flush_done", 64'(bus16.done), 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus16.done) seen = 1'b1;
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_r0_held", 64'(bus16.result_0), 64'hFFFF);
        check("flush_r1_held", 64'(bus16.result_1), 64'h0014);
        check("flush_flags_held", 64'(bus16.next_flags), 64'h0042);
        @(negedge clk);
        bus16.start = 1'b1; bus16.flush = 1'b1;
        @(posedge clk);
        #1;
        bus16.start = 1'b0; bus16.flush = 1'b0;
        check("flush_blocks_start", 64'(bus16.busy), 64'd0);
        run16(1'b0, 16'd10, 16'd20, 16'h0000, lat, bsy);
        check("mul2_latency", 64'(lat), 64'd17);
        check("mul2_r0", 64'(bus16.result_0), 64'h00C8);
        check("mul2_r1", 64'(bus16.result_1), 64'h0000);
        check("mul2_flags", 64'(bus16.next_flags), 64'h0000);

        // 5: start in the DONE cycle, and ignored starts while busy
        run16(1'b0, 16'd3, 16'd3, 16'h0000, lat, bsy);
        check("mul3_r0", 64'(bus16.result_0), 64'h0009);
        bus16.start = 1'b1; bus16.op_div = 1'b1;
        bus16.operand_1 = 16'd100; bus16.operand_2 = 16'd7;
        check("mul3_done_high", 64'(bus16.done), 64'd1);
        @(posedge clk);
        #1;
        bus16.start = 1'b0; bus16.op_div = 1'b0;
        bus16.operand_1 = 16'd5; bus16.operand_2 = 16'd5;
        n = 1;
        check("b2b_accepted", 64'(bus16.busy), 64'd1);
        check("b2b_single_pulse", 64'(bus16.done), 64'd0);
        while (!bus16.done && n < 60) begin
            bus16.start = (n == 5 || n == 9);
            @(posedge clk);
            #1;
            n++;
        end
        bus16.start = 1'b0;
        check("div3_latency", 64'(n), 64'd17);
        check("div3_r0", 64'(bus16.result_0), 64'h000E);
        check("div3_r1", 64'(bus16.result_1), 64'h0002);
        check("div3_flags", 64'(bus16.next_flags), 64'h0000);
        @(posedge clk);
        #1;
        check("div3_no_restart", 64'(bus16.busy), 64'd0);

        // 6: asynchronous reset mid-MUL
        @(negedge clk);
        bus16.start = 1'b1; bus16.operand_1 = 16'hFFFF; bus16.operand_2 = 16'hFFFF;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(bus16.busy), 64'd0);
        check("arst_done", 64'(bus16.done), 64'd0);
        check("arst_r0", 64'(bus16.result_0), 64'd0);
        check("arst_r1", 64'(bus16.result_1), 64'd0);
        check("arst_flags", 64'(bus16.next_flags), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(bus16.busy), 64'd0);

        // WIDTH=32: 0xFFFFFFFF x 2
        @(negedge clk);
        bus32.start = 1'b1; bus32.op_div = 1'b0;
        bus32.operand_1 = 32'hFFFF_FFFF; bus32.operand_2 = 32'd2; bus32.current_flags = 16'h0;
        @(posedge clk);
        #1;
        bus32.start = 1'b0;
        n = 1;
        while (!bus32.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w32_latency", 64'(n), 64'd33);
        check("w32_r1", 64'(bus32.result_1), 64'h0000_0001);
        check("w32_r0", 64'(bus32.result_0), 64'hFFFF_FFFE);
        check("w32_flags", 64'(bus32.next_flags), 64'h0041);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
